// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-ported data memory (IDLE -> ACCESS -> RESP).
// Define DMEM_ARB_RR_EN for round-robin arbitration of simultaneous requests; otherwise port 0 has priority.
module dmem_arbiter #(
    parameter int MEM_WIDTH = 32,
    parameter int ADDR_SIZE = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [ADDR_SIZE-1:0] m0_addr,
    input  logic [MEM_WIDTH-1:0] m0_wdata,
    output logic                 m0_gnt,
    output logic                 m0_rvalid,
    output logic [MEM_WIDTH-1:0] m0_rdata,
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [ADDR_SIZE-1:0] m1_addr,
    input  logic [MEM_WIDTH-1:0] m1_wdata,
    output logic                 m1_gnt,
    output logic                 m1_rvalid,
    output logic [MEM_WIDTH-1:0] m1_rdata,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [MEM_WIDTH-1:0] mem_din,
    output logic                 mem_w_en,
    output logic                 mem_R_en,
    input  logic [MEM_WIDTH-1:0] mem_dout
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 we_q, we_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [MEM_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]           rvalid_q, rvalid_d;
    logic [MEM_WIDTH-1:0] rdata_q [2];
    logic [MEM_WIDTH-1:0] rdata_d [2];
    logic [1:0]           gnt;
    logic                 can_accept;
    logic                 prefer0;
    logic                 accept;
    logic                 in_range;

`ifdef DMEM_ARB_RR_EN
    logic last_q, last_d;
`endif

    assign in_range = addr_q < ADDR_SIZE'(MEM_DEPTH);
    assign accept   = gnt[0] | gnt[1];

    // Grants are gated by rst so nothing is offered while reset is held.
    always_comb begin
        can_accept = rst && (state_q == IDLE || state_q == RESP);
`ifdef DMEM_ARB_RR_EN
        prefer0 = last_q;
`else
        prefer0 = 1'b1;
`endif
        gnt[0] = can_accept && m0_req && (!m1_req || prefer0);
        gnt[1] = can_accept && m1_req && !gnt[0];
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rvalid_d = '0;
        for (int i = 0; i < 2; i++) rdata_d[i] = rdata_q[i];
`ifdef DMEM_ARB_RR_EN
        last_d = last_q;
`endif
        case (state_q)
            IDLE, RESP: state_d = accept ? ACCESS : IDLE;
            ACCESS: begin
                state_d           = RESP;
                rvalid_d[owner_q] = 1'b1;
                if (!we_q) rdata_d[owner_q] = in_range ? mem_dout : '0;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            owner_d = gnt[1];
            we_d    = gnt[1] ? m1_we    : m0_we;
            addr_d  = gnt[1] ? m1_addr  : m0_addr;
            wdata_d = gnt[1] ? m1_wdata : m0_wdata;
`ifdef DMEM_ARB_RR_EN
            last_d  = gnt[1];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rvalid_q   <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
`ifdef DMEM_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rvalid_q   <= rvalid_d;
            rdata_q[0] <= rdata_d[0];
            rdata_q[1] <= rdata_d[1];
`ifdef DMEM_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = rdata_q[0];
    assign m1_rdata  = rdata_q[1];
    assign mem_addr  = addr_q;
    assign mem_din   = wdata_q;
    // Enables decode straight from state so an async reset drops them at once.
    assign mem_w_en  = (state_q == ACCESS) &&  we_q && in_range;
    assign mem_R_en  = (state_q == ACCESS) && !we_q && in_range;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a cycle-timeline transaction model with its own memory image.
module tb_dmem_arbiter;
    localparam int W = 32;
    localparam int A = 32;
    localparam int D = 1024;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         m0_req, m0_we, m1_req, m1_we;
    logic [A-1:0] m0_addr, m1_addr;
    logic [W-1:0] m0_wdata, m1_wdata;
    logic         m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [W-1:0] m0_rdata, m1_rdata;
    logic [A-1:0] mem_addr;
    logic [W-1:0] mem_din, mem_dout;
    logic         mem_w_en, mem_R_en;

    dmem_arbiter #(.MEM_WIDTH(W), .ADDR_SIZE(A), .MEM_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_w_en(mem_w_en), .mem_R_en(mem_R_en),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Memory behind the arbiter; out-of-range addresses alias so a missing zero-force shows up.
    logic [W-1:0] tb_mem [D];
    logic         init_en = 1'b0;
    logic [31:0]  seed;

    function automatic logic [31:0] preload(input int i);
        return (32'(i) * 32'h9E3779B1) ^ seed;
    endfunction

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < D; i++) tb_mem[i] <= preload(i);
        end else if (mem_w_en) begin
            tb_mem[mem_addr[9:0]] <= mem_din;
        end
    end
    assign mem_dout = tb_mem[mem_addr[9:0]];

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: last accepted transaction and the cycle it was accepted in.
    logic [31:0] ref_mem [D];
    logic [31:0] hold [2];
    int          cyc    = 0;
    int          last_k = -100;
    logic        lp, lwe, ls;
    logic [31:0] la, ld, exp_rd;

    task automatic run_cycle(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                             input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                             output logic acc);
        logic inr, can, pref0, e0, e1;
        @(negedge clk);
        inr = la < 32'(D);
        if (cyc == last_k + 1) begin
            check_val("mem_w_en", mem_w_en, inr && lwe);
            check_val("mem_R_en", mem_R_en, inr && !lwe);
            check_val("mem_addr", mem_addr, la);
            if (lwe) check_val("mem_din", mem_din, ld);
        end else begin
            check_val("mem_w_en_idle", mem_w_en, 0);
            check_val("mem_R_en_idle", mem_R_en, 0);
        end
        if (cyc == last_k + 2) begin
            if (!lwe) hold[lp] = exp_rd;
            check_val("m0_rvalid", m0_rvalid, lp == 1'b0);
            check_val("m1_rvalid", m1_rvalid, lp == 1'b1);
            $display("txn port=%0d %s addr=%0h data=%0h", lp, lwe ? "wr" : "rd", la, lwe ? ld : exp_rd);
        end else begin
            check_val("m0_rvalid_idle", m0_rvalid, 0);
            check_val("m1_rvalid_idle", m1_rvalid, 0);
        end
        check_val("m0_rdata", m0_rdata, hold[0]);
        check_val("m1_rdata", m1_rdata, hold[1]);

        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        #1;
        can = cyc >= last_k + 2;
`ifdef DMEM_ARB_RR_EN
        pref0 = ls;
`else
        pref0 = 1'b1;
`endif
        e0 = can && r0 && (!r1 || pref0);
        e1 = can && r1 && !e0;
        check_val("m0_gnt", m0_gnt, e0);
        check_val("m1_gnt", m1_gnt, e1);
        acc = e0 || e1;
        if (acc) begin
            last_k = cyc;
            lp  = e1;
            lwe = e1 ? w1 : w0;
            la  = e1 ? a1 : a0;
            ld  = e1 ? d1 : d0;
            ls  = e1;
            exp_rd = 32'h0;
            if (la < 32'(D)) begin
                if (lwe) ref_mem[la] = ld;
                else     exp_rd = ref_mem[la];
            end
        end
        cyc++;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 32'(D) + $urandom_range(0, 3);
        return $urandom_range(0, 15);
    endfunction

    logic        acc;
    logic [31:0] old7;
    int          idx, guard;

    initial begin
        seed = $urandom;
        for (int i = 0; i < D; i++) ref_mem[i] = preload(i);
        hold[0] = 0; hold[1] = 0; ls = 1'b1; lp = 0; lwe = 0; la = 0; ld = 0; exp_rd = 0;
        m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        init_en = 1;
        @(posedge clk); #1 init_en = 0;
        #1;
        check_val("rst_m0_gnt", m0_gnt, 0);
        check_val("rst_m1_gnt", m1_gnt, 0);
        check_val("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
        check_val("rst_mem_en", {mem_w_en, mem_R_en}, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_mem_din", mem_din, 0);
        check_val("rst_rdata", {m0_rdata, m1_rdata}, 0);
        m0_req = 0; m1_req = 0;
        @(negedge clk) rst = 1;

        // Write then read back address 5 from port 0.
        run_cycle(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, acc);
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);
        run_cycle(1, 0, 5, 0, 0, 0, 0, 0, acc);
        repeat (3) run_cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);
        // Out-of-range read from port 1.
        run_cycle(0, 0, 0, 0, 1, 0, 1024, 0, acc);
        repeat (3) run_cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);
        // Both ports requesting every cycle.
        repeat (9) run_cycle(1, 0, $urandom_range(0, 15), 0, 1, 0, $urandom_range(0, 15), 0, acc);
        repeat (3) run_cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);
        // Continuous reads of 0..3 on port 0.
        idx = 0; guard = 0;
        while (idx < 4 && guard < 20) begin
            run_cycle(1, 0, 32'(idx), 0, 0, 0, 0, 0, acc);
            if (acc) idx++;
            guard++;
        end
        repeat (3) run_cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);

        for (int n = 0; n < 400; n++) begin
            run_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rand_addr(), $urandom,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rand_addr(), $urandom, acc);
        end
        repeat (3) run_cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);

        // Reset in the middle of a write to address 7.
        old7 = ref_mem[7];
        run_cycle(1, 1, 7, 32'h12345678, 0, 0, 0, 0, acc);
        @(posedge clk); #2;
        check_val("rstw_pre_wen", mem_w_en, 1);
        rst = 0;
        #1;
        check_val("rstw_wen", mem_w_en, 0);
        check_val("rstw_mem_addr", mem_addr, 0);
        check_val("rstw_mem_din", mem_din, 0);
        m0_req = 1;
        repeat (3) begin
            @(negedge clk);
            check_val("rstw_rvalid", m0_rvalid, 0);
            check_val("rstw_gnt", m0_gnt, 0);
            check_val("rstw_wen_hold", mem_w_en, 0);
        end
        m0_req = 0;
        check_val("rstw_mem7", tb_mem[7], old7);
        ref_mem[7] = old7;
        last_k = -100; ls = 1'b1; hold[0] = 0; hold[1] = 0; la = 0;
        rst = 1;

        for (int n = 0; n < 60; n++) begin
            run_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rand_addr(), $urandom,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rand_addr(), $urandom, acc);
        end
        repeat (3) run_cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter ADDR_SIZE, default 32, address width.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, number of valid word addresses.
REQ-004 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports m0_req/m1_req  input  1  requester N wants an access.
REQ-007 SHALL have ports m0_we/m1_we  input  1  1=write, 0=read.
REQ-008 SHALL have ports m0_addr/m1_addr  input  ADDR_SIZE  word address.
REQ-009 SHALL have ports m0_wdata/m1_wdata  input  MEM_WIDTH  write data.
REQ-010 SHALL have ports m0_gnt/m1_gnt  output  1  request accepted this cycle (combinational from state and req).
REQ-011 SHALL have ports m0_rvalid/m1_rvalid  output  1  one-cycle completion pulse, reads and writes.
REQ-012 SHALL have ports m0_rdata/m1_rdata  output  MEM_WIDTH  registered read data, valid with rvalid.
REQ-013 SHALL have port mem_addr  output  ADDR_SIZE  to memory addr.
REQ-014 SHALL have port mem_din  output  MEM_WIDTH  to memory din.
REQ-015 SHALL have ports mem_w_en/mem_R_en  output  1  memory write/read enables.
REQ-016 SHALL have port mem_dout  input  MEM_WIDTH  combinational memory read data.

Function
REQ-017 SHALL implement FSM IDLE, ACCESS, RESP.
REQ-018 SHALL assert mN_gnt only in IDLE or RESP, to at most one port, only when mN_req=1; transfer accepted when req&&gnt at a rising edge.
REQ-019 On accept, SHALL latch owner, we, addr, wdata and go to ACCESS; with no accept, IDLE stays IDLE and RESP goes to IDLE.
REQ-020 In ACCESS, SHALL drive mem_addr/mem_din from the latched values, assert exactly one of mem_w_en (we=1) or mem_R_en (we=0) for exactly one cycle, then go to RESP.
REQ-021 At the end of an ACCESS read, SHALL capture mem_dout into the owner's rdata register; a write SHALL leave rdata unchanged.
REQ-022 In RESP, SHALL pulse the owner's rvalid for exactly one cycle; the other port's rvalid SHALL stay 0.
REQ-023 Latency: accept at edge T, memory access in cycle T..T+1, rvalid high in cycle T+1..T+2; back-to-back accepts allowed every 2 cycles (accept in RESP).
REQ-024 Out-of-range address (addr >= MEM_DEPTH): no mem enable asserted in ACCESS; RESP still pulses rvalid; rdata forced to 0 for reads.
REQ-025 Outside ACCESS, mem_w_en=0 and mem_R_en=0; mem_addr and mem_din hold last latched values.
REQ-026 A requester deasserting req without a grant SHALL be ignored; req/addr changes after accept SHALL NOT affect the in-flight access.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, all gnt/rvalid/mem enables 0, rdata 0, mem_addr/mem_din 0, last-served = port 1.
REQ-028 Reset during ACCESS or RESP SHALL abandon the access: no write completes after reset assertion, no rvalid issued.

Configuration
REQ-029 With DMEM_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the port not last served wins; last-served updates on each accept.
REQ-030 Without DMEM_ARB_RR_EN, port 0 SHALL always win simultaneous requests; port 1 granted only when m0_req=0.

Verification
REQ-031 m0 write addr 5 data 0xDEADBEEF, then m0 read addr 5 -> mem_w_en one cycle with mem_addr=5, later m0_rvalid with m0_rdata=0xDEADBEEF.
REQ-032 m0 and m1 both request every cycle, RR build -> grants alternate 0,1,0,1; non-RR build -> m1_gnt never asserted.
REQ-033 m1 read addr 1024 -> no mem_R_en, m1_rvalid one cycle, m1_rdata=0.
REQ-034 rst pulled low in ACCESS of a write to addr 7 -> outputs 0 immediately, no m0_rvalid, memory word 7 unchanged.
REQ-035 Continuous m0 reads addr 0..3 -> accepts every 2 cycles, rvalid one cycle after each access, rdata matches preloaded values.
